// File: rtl/mole_picker.sv
// Whack-a-mole picker: draws a random hole different from the last one, holds it up
// for a randomized number of ticks, and scores the outcome as a hit or a miss.
module mole_picker #(
    parameter int         NUM_MOLES = 9,
    parameter logic [7:0] MIN_UP    = 8'd20
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] rand_in,
    input  logic       req,
    input  logic       tick,
    input  logic       hit,
    output logic       mole_up,
    output logic [3:0] mole_idx,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PICK     = 2'd1;
    localparam logic [1:0] UP       = 2'd2;
    localparam logic [1:0] FALLBACK = 2'd3;

    localparam logic [4:0] NM       = 5'(NUM_MOLES);
    localparam logic [3:0] LAST_IDX = 4'(NUM_MOLES - 1);
    localparam logic [3:0] MAX_REJ  = 4'd14;

    logic [1:0] r_state;
    logic [3:0] r_mole_idx;
    logic [7:0] r_timer;
    logic [3:0] r_retry;
    logic       r_raised;
    logic       r_mole_up;
    logic       r_hit_pulse;
    logic       r_miss_pulse;
    logic [7:0] r_hit_count;
    logic [7:0] r_miss_count;

    logic [3:0] w_cand;
    logic       w_accept;
    logic [3:0] w_next_idx;
    logic [7:0] w_timer_load;
    logic [7:0] w_hit_inc;
    logic [7:0] w_miss_inc;

    assign w_cand       = rand_in[3:0];
    // The first pick after reset may land on any hole, including hole 0.
    assign w_accept     = ({1'b0, w_cand} < NM) && (!r_raised || (w_cand != r_mole_idx));
    assign w_next_idx   = (r_mole_idx == LAST_IDX) ? 4'd0 : r_mole_idx + 4'd1;
    assign w_timer_load = MIN_UP + {4'd0, rand_in[7:4]};
    assign w_hit_inc    = (r_hit_count  == 8'hFF) ? r_hit_count  : r_hit_count  + 8'd1;
    assign w_miss_inc   = (r_miss_count == 8'hFF) ? r_miss_count : r_miss_count + 8'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_mole_idx   <= 4'd0;
            r_timer      <= 8'd0;
            r_retry      <= 4'd0;
            r_raised     <= 1'b0;
            r_mole_up    <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_hit_count  <= 8'd0;
            r_miss_count <= 8'd0;
        end else begin
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_state <= PICK;
                        r_retry <= 4'd0;
                    end
                end
                PICK: begin
                    if (w_accept) begin
                        r_mole_idx <= w_cand;
                        r_timer    <= w_timer_load;
                        r_mole_up  <= 1'b1;
                        r_raised   <= 1'b1;
                        r_state    <= UP;
                    end else begin
                        r_retry <= r_retry + 4'd1;
                        if (r_retry == MAX_REJ) r_state <= FALLBACK;
                    end
                end
                FALLBACK: begin
                    // Unraised mole_idx is still 0, so the first fallback lands on hole 1.
                    r_mole_idx <= w_next_idx;
                    r_timer    <= MIN_UP;
                    r_mole_up  <= 1'b1;
                    r_raised   <= 1'b1;
                    r_state    <= UP;
                end
                UP: begin
                    if (hit) begin
                        r_hit_pulse <= 1'b1;
                        r_hit_count <= w_hit_inc;
                        r_mole_up   <= 1'b0;
                        r_state     <= IDLE;
                    end else if (tick) begin
                        if (r_timer == 8'd1) begin
                            r_miss_pulse <= 1'b1;
                            r_miss_count <= w_miss_inc;
                            r_mole_up    <= 1'b0;
                            r_state      <= IDLE;
                        end else if (r_timer > 8'd1) begin
                            r_timer <= r_timer - 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mole_up    = r_mole_up;
    assign mole_idx   = r_mole_idx;
    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: doc/mole_picker.md
MOLE_PICKER -- requirements
Module: mole_picker

Interface
REQ-001 Parameter NUM_MOLES, default 9: number of mole holes, legal range 2..16.
REQ-002 Parameter MIN_UP, default 8'd20: minimum mole-up time in tick periods.
REQ-003 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1: asynchronous, active-low reset.
REQ-005 Port rand_in, input, 8: free-running pseudo-random byte from the random generator, new value each clock.
REQ-006 Port req, input, 1: request a new mole; sampled only in IDLE.
REQ-007 Port tick, input, 1: single-cycle time-base enable.
REQ-008 Port hit, input, 1: player strike on the currently raised mole.
REQ-009 Port mole_up, output, 1: a mole is raised.
REQ-010 Port mole_idx, output, 4: index of the raised or last-raised mole.
REQ-011 Port hit_pulse, output, 1: one-cycle pulse when a raised mole is hit.
REQ-012 Port miss_pulse, output, 1: one-cycle pulse when a raised mole times out.
REQ-013 Port hit_count, output, 8: saturating count of hits.
REQ-014 Port miss_count, output, 8: saturating count of misses.

Function
REQ-015 The FSM SHALL have four states: IDLE, PICK, UP and FALLBACK.
REQ-016 In IDLE with req=1, the FSM SHALL enter PICK on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 In PICK, each cycle SHALL form cand = rand_in[3:0] and accept it when cand < NUM_MOLES and either no mole has been raised since reset or cand != mole_idx.
REQ-018 On accept, the block SHALL load mole_idx=cand and timer=MIN_UP+rand_in[7:4] (8-bit, no overflow for the default), set mole_up=1 and enter UP; this is one cycle after the accepting sample.
REQ-019 On reject, PICK SHALL increment a 4-bit retry counter and stay in PICK.
REQ-020 After 15 consecutive rejects, the FSM SHALL enter FALLBACK.
REQ-021 FALLBACK SHALL load mole_idx=(mole_idx+1) mod NUM_MOLES, treating mole_idx=0 when no mole has yet been raised, and SHALL load timer=MIN_UP; it then enters UP with mole_up=1.
REQ-022 The retry counter SHALL clear on every entry to PICK.
REQ-023 In UP with hit=1, the block SHALL drive hit_pulse=1 for one cycle, increment hit_count, clear mole_up and return to IDLE.
REQ-024 In UP with tick=1 and timer=1 and hit=0, the block SHALL drive miss_pulse=1 for one cycle, increment miss_count, clear mole_up and return to IDLE.
REQ-025 In UP with tick=1 and timer>1, the timer SHALL decrement by 1.
REQ-026 When hit and expiry occur in the same cycle, hit SHALL win: a hit_pulse is produced and no miss_pulse.
REQ-027 hit and tick SHALL be ignored outside UP; req SHALL be ignored outside IDLE.
REQ-028 hit_count and miss_count SHALL saturate at 255 and never wrap.
REQ-029 mole_idx SHALL hold its value in IDLE for display.
REQ-030 hit_pulse and miss_pulse SHALL never be asserted simultaneously.

Reset
REQ-031 While resetn=0, the block SHALL force state=IDLE, mole_up=0, mole_idx=0, hit_pulse=0, miss_pulse=0, hit_count=0, miss_count=0, timer=0, retry=0 and clear the "raised since reset" flag.
REQ-032 Reset asserted mid-UP SHALL drop mole_up immediately (asynchronously) with no pulse generated.
REQ-033 After resetn deasserts, the block SHALL act only on the first req.

Verification
REQ-034 req with rand_in=8'h34 -> next cycle mole_up=1, mole_idx=4, timer=23; after 23 ticks -> miss_pulse once, miss_count=1.
REQ-035 mole_idx=4 last; req with rand_in held 8'h04 for 15 cycles -> FALLBACK -> mole_idx=5, timer=20.
REQ-036 rand_in=8'h0C (12 >= 9) on the first sample, then 8'h02 -> accepted on the second sample, mole_idx=2.
REQ-037 In UP, hit=1 and tick=1 with timer=1 in the same cycle -> hit_pulse=1, miss_pulse=0, hit_count+1.
REQ-038 Drive 300 hits -> hit_count=255 and stays there.
REQ-039 resetn low during UP -> mole_up=0 before the next edge, counts=0, no pulses.
